// File: rtl/dmem_arbiter_if.sv
// Bundle of requester ports and memory-side signals for dmem_arbiter.
// slave = arbiter side, master = requesters plus data memory.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, err, rdata,
               mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, err, rdata,
               mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one transaction in flight.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        winner;
    logic        in_range;

`ifdef DMEM_ARB_RR_EN
    // last_q = port served most recently; resets to 1 so port 0 wins first.
    logic last_q, last_d;

    always_comb begin
        if (bus.req0 && bus.req1) winner = ~last_q;
        else                      winner = ~bus.req0;
    end
`else
    always_comb begin
        winner = ~bus.req0;
    end
`endif

    assign in_range = (addr_q[31:8] == 24'd0);

    // NOTE: every _d gets its default (hold) first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ST_ACCESS;
                    port_d  = winner;
                    we_d    = winner ? bus.we1    : bus.we0;
                    addr_d  = winner ? bus.addr1  : bus.addr0;
                    wdata_d = winner ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_RR_EN
                    last_d  = winner;
`endif
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                err_d   = ~in_range;
                rdata_d = (!we_q && in_range) ? bus.mem_rdata : 32'd0;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            err_q   <= err_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // NOTE: datapath registers are left unreset; every output they feed is gated by state.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    assign bus.gnt0      = (state_q == ST_ACCESS) && !port_q;
    assign bus.gnt1      = (state_q == ST_ACCESS) &&  port_q;
    assign bus.mem_addr  = (state_q == ST_ACCESS) ? addr_q  : 32'd0;
    assign bus.mem_wdata = (state_q == ST_ACCESS) ? wdata_q : 32'd0;
    assign bus.mem_write = (state_q == ST_ACCESS) &&  we_q && in_range;
    assign bus.mem_read  = (state_q == ST_ACCESS) && !we_q && in_range;
    assign bus.done0     = (state_q == ST_RESP) && !port_q;
    assign bus.done1     = (state_q == ST_RESP) &&  port_q;
    assign bus.err       = (state_q == ST_RESP) && err_q;
    assign bus.rdata     = (state_q == ST_RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: memory model, directed scenarios and random traffic
// against a transaction-level reference (same DMEM_ARB_RR_EN setting as the DUT).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory seen by the DUT; preloaded with mem[i] = i.
    logic [31:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    bit          last_port;
    int          n_checks;
    int          n_fail;

    function automatic bit pick_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return (last_port == 1'b0) ? 1'b1 : 1'b0;
`else
            return 1'b0;
`endif
        end
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic drive_idle();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_write, bus.mem_read} !== 7'd0 ||
            bus.rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: gnt=%b%b done=%b%b err=%b wr/rd=%b%b rdata=%h maddr=%h mwdata=%h, required all 0",
                     name, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_write,
                     bus.mem_read, bus.rdata, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    // One complete transaction from an IDLE cycle; checks the ACCESS and RESP cycles.
    task automatic run_txn(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                           input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        bit          win, w, oor;
        logic [31:0] a, d, exp_rd;
        @(negedge clk);
        check_all_zero("idle");
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;

        win       = pick_winner(r0, r1);
        last_port = win;
        w   = win ? w1 : w0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        oor = (a > 32'd255);
        exp_rd = (!w && !oor) ? ref_mem[a[7:0]] : 32'd0;
        if (w && !oor) ref_mem[a[7:0]] = d;

        @(negedge clk);
        drive_idle();
        n_checks++;
        if ({bus.gnt0, bus.gnt1} !== (win ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL access_gnt: gnt0/1=%b%b, required %b", bus.gnt0, bus.gnt1, win ? 2'b01 : 2'b10);
        end
        n_checks++;
        if ({bus.mem_write, bus.mem_read} !== {w && !oor, !w && !oor}) begin
            n_fail++;
            $display("FAIL access_strobes: wr/rd=%b%b, required %b%b", bus.mem_write, bus.mem_read,
                     w && !oor, !w && !oor);
        end
        n_checks++;
        if (bus.mem_addr !== a || bus.mem_wdata !== d) begin
            n_fail++;
            $display("FAIL access_bus: maddr=%h mwdata=%h, required %h %h", bus.mem_addr, bus.mem_wdata, a, d);
        end
        n_checks++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL access_done: done0/1=%b%b, required 00", bus.done0, bus.done1);
        end

        @(negedge clk);
        n_checks++;
        if ({bus.done0, bus.done1, bus.err} !== {!win, win, oor}) begin
            n_fail++;
            $display("FAIL resp_done: done0/1/err=%b%b%b, required %b%b%b", bus.done0, bus.done1, bus.err,
                     !win, win, oor);
        end
        n_checks++;
        if (bus.rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL resp_rdata: rdata=%h, required %h", bus.rdata, exp_rd);
        end
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read} !== 4'd0) begin
            n_fail++;
            $display("FAIL resp_quiet: gnt=%b%b wr/rd=%b%b, required 0", bus.gnt0, bus.gnt1,
                     bus.mem_write, bus.mem_read);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n   = 0;
        preload = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = i;
        last_port = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n   = 1;
        preload = 0;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_back_to_back();
        bit exp_port, got;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'd1;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'd2;
        for (int t = 0; t < 4; t++) begin
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (bus.gnt0 || bus.gnt1) got = 1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL b2b_timeout: no grant for transaction %0d, required one within 8 cycles", t);
            end else begin
                exp_port  = pick_winner(1'b1, 1'b1);
                last_port = exp_port;
                n_checks++;
                if ({bus.gnt0, bus.gnt1} !== (exp_port ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL b2b_grant%0d: gnt0/1=%b%b, required port %0d", t, bus.gnt0, bus.gnt1, exp_port);
                end
                if (t == 3) drive_idle();
                @(negedge clk);
                n_checks++;
                if ({bus.done0, bus.done1} !== (exp_port ? 2'b01 : 2'b10) ||
                    bus.rdata !== (exp_port ? 32'd2 : 32'd1)) begin
                    n_fail++;
                    $display("FAIL b2b_done%0d: done0/1=%b%b rdata=%h, required port %0d rdata %0d", t,
                             bus.done0, bus.done1, bus.rdata, exp_port, exp_port ? 2 : 1);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_read();
        run_txn(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_write();
        run_txn(0, 0, 32'd0, 32'd0, 1, 1, 32'd10, 32'hDEADBEEF);
        run_txn(1, 0, 32'd10, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_out_of_range();
        run_txn(1, 0, 32'h100, 32'd0, 0, 0, 32'd0, 32'd0);
        run_txn(0, 0, 32'd0, 32'd0, 1, 1, 32'h8000_0003, 32'h1234_5678);
        run_txn(1, 0, 32'd3, 32'd0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.req0 = 1; bus.addr0 = 32'd7;
        bus.req1 = 1; bus.addr1 = 32'd8;
        @(negedge clk);
        drive_idle();
        rst_n = 0;
        @(negedge clk);
        check_all_zero("abort_after_reset");
        rst_n     = 1;
        last_port = 1'b1;
        @(negedge clk);
        check_all_zero("abort_no_done");
        run_txn(1, 0, 32'd7, 32'd0, 1, 0, 32'd8, 32'd0);
    endtask

    task automatic test_random();
        bit          r0, r1, w0, w1;
        logic [31:0] a0, a1;
        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = ($urandom_range(0, 7) == 0) ? (32'h100 | $urandom) : 32'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 7) == 0) ? (32'h100 | $urandom) : 32'($urandom_range(0, 15));
            run_txn(r0, w0, a0, $urandom, r1, w1, a1, $urandom);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        preload  = 1;
        drive_idle();
        test_reset();
        test_back_to_back();
        test_read();
        test_write();
        test_out_of_range();
        test_reset_abort();
        test_random();
        @(negedge clk);
        check_all_zero("final_idle");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
